psram_xfer_engine: RTL

Single-transaction pin sequencer that sits directly downstream of the PSRAM register file and drives the dut side of psram_if.
- On a start pulse it issues one command byte, a 24-bit address, programmable wait cycles and one data byte, then closes the transaction.
- Supported lane modes: SPI, QSPI, QPI and OPI, all SDR.
- Reports busy, a completion pulse and the read byte back to the register file, which feeds PSRAM_STAT.DONE and PSRAM_DATA.

---
 rtl/psram_xfer_engine.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/psram_xfer_engine.sv
// Single-transaction PSRAM pin sequencer: command, address, optional wait, one data byte.
// SDR lane modes SPI/QSPI/QPI/OPI; SCK half-period comes from a reloading prescaler.
module psram_xfer_engine #(
   parameter int ADDR_WIDTH = 24,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic                  wr_i,
   input  logic [1:0]            mode_i,
   input  logic [7:0]            pscr_i,
   input  logic [7:0]            cmd_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [7:0]            wait_i,
   input  logic [7:0]            wr_data_i,
   output logic [7:0]            rd_data_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  psram_sck_o,
   output logic                  psram_ce_o,
   output logic [7:0]            psram_io_en_o,
   output logic [7:0]            psram_io_out_o,
   input  logic [7:0]            psram_io_in_i
);

   localparam int SR_W = ADDR_WIDTH + 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_WAIT,
      ST_DATA,
      ST_HOLD
   } state_e;

   typedef enum logic [1:0] {
      LN_1,
      LN_4,
      LN_8
   } lanes_e;

   state_e               state_q, state_d;
   logic                 sck_q, sck_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0] half_q, half_d;
   logic [CNT_WIDTH-1:0] ph_q, ph_d;
   logic [SR_W-1:0]      sr_q, sr_d;
   logic [7:0]           rx_q, rx_d;
   logic [7:0]           rd_data_q, rd_data_d;
   logic [7:0]           wait_q, wait_d;
   logic                 wr_q, wr_d;
   logic                 done_q, done_d;
   logic [1:0]           mode_q, mode_d;

   logic                 tick;
   lanes_e               lanes;
   logic [7:0]           pscr_m1;
   state_e               nxt;
   logic                 drive;

   function automatic lanes_e lanes_of(input state_e st, input logic [1:0] mode);
      lanes_e l;
      case (mode)
         2'b00:   l = LN_1;
         2'b01:   l = (st == ST_CMD) ? LN_1 : LN_4;
         2'b10:   l = LN_4;
         default: l = LN_8;
      endcase
      return l;
   endfunction

   // Length of a phase in SCK cycles minus one; HOLD counts two prescaler ticks.
   function automatic logic [CNT_WIDTH-1:0] phase_last(input state_e st, input logic [1:0] mode,
                                                       input logic [7:0] wait_cycles);
      int nbits;
      int len;
      nbits = (st == ST_ADDR) ? ADDR_WIDTH : 8;
      case (lanes_of(st, mode))
         LN_1:    len = nbits;
         LN_4:    len = nbits / 4;
         default: len = nbits / 8;
      endcase
      if (st == ST_WAIT) len = int'(wait_cycles);
      if (st == ST_HOLD) len = 2;
      return CNT_WIDTH'(len - 1);
   endfunction

   assign tick    = (cnt_q == '0);
   assign lanes   = lanes_of(state_q, mode_q);
   assign pscr_m1 = (pscr_i < 8'd2) ? 8'd1 : pscr_i - 8'd1;

   always_comb begin
      state_d   = state_q;
      sck_d     = sck_q;
      cnt_d     = cnt_q;
      half_d    = half_q;
      ph_d      = ph_q;
      sr_d      = sr_q;
      rx_d      = rx_q;
      rd_data_d = rd_data_q;
      wait_d    = wait_q;
      wr_d      = wr_q;
      mode_d    = mode_q;
      done_d    = 1'b0;
      nxt       = ST_IDLE;

      case (state_q)
         ST_IDLE: begin
            // Start is not taken in the completion cycle itself.
            if (start_i && !done_q) begin
               wr_d    = wr_i;
               mode_d  = mode_i;
               wait_d  = wait_i;
               half_d  = CNT_WIDTH'(pscr_m1);
               cnt_d   = CNT_WIDTH'(pscr_m1);
               sr_d    = {cmd_i, addr_i, wr_data_i};
               ph_d    = phase_last(ST_CMD, mode_i, wait_i);
               rx_d    = '0;
               sck_d   = 1'b0;
               state_d = ST_CMD;
            end
         end

         ST_HOLD: begin
            cnt_d = tick ? half_q : cnt_q - CNT_WIDTH'(1);
            if (tick) begin
               if (ph_q == '0) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
                  if (!wr_q) rd_data_d = rx_q;
               end else begin
                  ph_d = ph_q - CNT_WIDTH'(1);
               end
            end
         end

         ST_CMD, ST_ADDR, ST_WAIT, ST_DATA: begin
            cnt_d = tick ? half_q : cnt_q - CNT_WIDTH'(1);
            if (tick) begin
               sck_d = ~sck_q;
               if (!sck_q) begin
                  if (state_q == ST_DATA && !wr_q) begin
                     case (lanes)
                        LN_1:    rx_d = {rx_q[6:0], psram_io_in_i[1]};
                        LN_4:    rx_d = {rx_q[3:0], psram_io_in_i[3:0]};
                        default: rx_d = psram_io_in_i;
                     endcase
                  end
               end else begin
                  if (state_q != ST_WAIT) begin
                     case (lanes)
                        LN_1:    sr_d = {sr_q[SR_W-2:0], 1'b0};
                        LN_4:    sr_d = {sr_q[SR_W-5:0], 4'b0};
                        default: sr_d = {sr_q[SR_W-9:0], 8'b0};
                     endcase
                  end
                  if (ph_q == '0) begin
                     case (state_q)
                        ST_CMD:  nxt = ST_ADDR;
                        ST_ADDR: nxt = (wait_q != 8'd0) ? ST_WAIT : ST_DATA;
                        ST_WAIT: nxt = ST_DATA;
                        default: nxt = ST_HOLD;
                     endcase
                     state_d = nxt;
                     ph_d    = phase_last(nxt, mode_q, wait_q);
                  end else begin
                     ph_d = ph_q - CNT_WIDTH'(1);
                  end
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         sck_q     <= 1'b0;
         cnt_q     <= '0;
         half_q    <= '0;
         ph_q      <= '0;
         sr_q      <= '0;
         rx_q      <= '0;
         rd_data_q <= '0;
         wait_q    <= '0;
         wr_q      <= 1'b0;
         done_q    <= 1'b0;
         mode_q    <= '0;
      end else begin
         state_q   <= state_d;
         sck_q     <= sck_d;
         cnt_q     <= cnt_d;
         half_q    <= half_d;
         ph_q      <= ph_d;
         sr_q      <= sr_d;
         rx_q      <= rx_d;
         rd_data_q <= rd_data_d;
         wait_q    <= wait_d;
         wr_q      <= wr_d;
         done_q    <= done_d;
         mode_q    <= mode_d;
      end
   end

   // Lanes are only driven while the engine itself owns the bus.
   always_comb begin
      drive          = (state_q == ST_CMD) || (state_q == ST_ADDR) || (state_q == ST_DATA && wr_q);
      psram_io_en_o  = '0;
      psram_io_out_o = '0;
      if (drive) begin
         case (lanes)
            LN_1: begin
               psram_io_en_o  = 8'h01;
               psram_io_out_o = {7'b0, sr_q[SR_W-1]};
            end
            LN_4: begin
               psram_io_en_o  = 8'h0F;
               psram_io_out_o = {4'b0, sr_q[SR_W-1 -: 4]};
            end
            default: begin
               psram_io_en_o  = 8'hFF;
               psram_io_out_o = sr_q[SR_W-1 -: 8];
            end
         endcase
      end
   end

   assign psram_ce_o  = (state_q == ST_IDLE) || (state_q == ST_HOLD);
   assign busy_o      = (state_q != ST_IDLE);
   assign psram_sck_o = sck_q;
   assign done_o      = done_q;
   assign rd_data_o   = rd_data_q;

endmodule
